uart_rx: RTL and testbench

Oversampling UART receiver that sits directly downstream of the UART clock generator. It consumes the generator's one-cycle `rx_clk_posedge` strobe (RX_CLKS_PER_BIT strobes per bit) and deserialises the `rx` line into parallel words. Each completed word is held in an output register under a valid/ack handshake, and the block flags framing and overrun errors. It feeds the UART host-side register/FIFO logic.

---
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop deserialiser with valid/ack output register.
// Optional parity stage is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx #(
  parameter int          RX_CLKS_PER_BIT = 8,
  parameter int          DATA_BITS       = 8,
  parameter int unsigned PARITY_ODD      = 0
) (
  input  logic                 main_clk,
  input  logic                 rst,
  input  logic                 rx_clk_posedge,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(RX_CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(RX_CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(RX_CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (RX_CLKS_PER_BIT < 4 || RX_CLKS_PER_BIT % 2 != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rxs_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   framing_err_q, framing_err_d;
  logic                   overrun_q, overrun_d;
  logic                   accept, frame_bad;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = PARITY_ODD[0];
  logic                   parity_bad_q, parity_bad_d;
  logic                   parity_err_q, parity_err_d;
  logic                   par_fail;
`endif

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    accept    = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    par_fail     = 1'b0;
`endif
    if (rx_clk_posedge) begin
      unique case (state_q)
        S_IDLE: if (!rxs_q) begin
          state_d = S_START;
          tick_d  = '0;
        end
        S_START: if (tick_q == TICK_MID) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            tick_d    = '0;
            bit_cnt_d = '0;
            state_d   = S_DATA;
`ifdef UART_RX_PARITY_EN
            parity_bad_d = 1'b0;
`endif
          end
        end else tick_d = tick_q + TW'(1);
        S_DATA: if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else tick_d = tick_q + TW'(1);
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (tick_q == TICK_LAST) begin
          tick_d       = '0;
          parity_bad_d = ((^shift_q) ^ rxs_q) != PAR_ODD;
          state_d      = S_STOP;
        end else tick_d = tick_q + TW'(1);
`endif
        S_STOP: if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (!rxs_q) begin
            frame_bad = 1'b1;
            state_d   = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad_q) begin
            par_fail = 1'b1;
            state_d  = S_IDLE;
`endif
          end else begin
            accept  = 1'b1;
            state_d = S_IDLE;
          end
        end else tick_d = tick_q + TW'(1);
        S_WAIT_HIGH: if (rxs_q) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Ack is handled every cycle; a same-cycle ack frees the register for the new word.
  always_comb begin
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    overrun_d     = overrun_q;
    framing_err_d = frame_bad;
`ifdef UART_RX_PARITY_EN
    parity_err_d  = par_fail;
`endif
    if (data_valid_q && data_ack) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (accept) begin
      if (!data_valid_q || data_ack) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      state_q       <= S_IDLE;
      tick_q        <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rx;
      rxs_q         <= rx_meta_q;
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= parity_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a
// frame-level model of the valid/ack/overrun/error behaviour.
module tb_uart_rx;

  localparam int   CPB     = 8;
  localparam logic PAR_ODD = 1'b0;

  logic       main_clk = 1'b0;
  logic       rst, strobe, rx, data_ack;
  logic [7:0] data_out;
  logic       data_valid, framing_err, parity_err, overrun, busy;

  int vectors     = 0;
  int miscompares = 0;
  int fe_count    = 0;
  int pe_count    = 0;
  int div;

  logic       exp_valid, exp_overrun;
  logic [7:0] exp_data;
  int         exp_fe, exp_pe;

  always #5 main_clk = ~main_clk;

  uart_rx dut (
    .main_clk       (main_clk),
    .rst            (rst),
    .rx_clk_posedge (strobe),
    .rx             (rx),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ack       (data_ack),
    .framing_err    (framing_err),
    .parity_err     (parity_err),
    .overrun        (overrun),
    .busy           (busy)
  );

  // Every cycle an error output is high counts as one pulse cycle.
  always @(negedge main_clk) begin
    if (framing_err) fe_count++;
    if (parity_err)  pe_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] w);
    return (^w) ^ PAR_ODD;
  endfunction

  // One strobe period: div-1 quiet cycles then one strobe cycle; returns #1 after its edge.
  task automatic strobe_period(input bit ack_on_strobe);
    for (int c = 0; c < div; c++) begin
      strobe   = (c == div - 1);
      data_ack = ack_on_strobe && (c == div - 1);
      @(posedge main_clk); #1;
    end
    strobe   = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic send_bits(input logic b, input int n);
    rx = b;
    repeat (n) strobe_period(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop_bit,
                            input logic par_bit, input bit ack_at_stop);
    logic par_exp, frame_exp, accept_exp;
    send_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bits(w[i], CPB);
`ifdef UART_RX_PARITY_EN
    send_bits(par_bit, CPB);
    par_exp = stop_bit && (((^w) ^ par_bit) != PAR_ODD);
`else
    par_exp = 1'b0 & par_bit;
`endif
    frame_exp  = !stop_bit;
    accept_exp = stop_bit && !par_exp;
    rx = stop_bit;
    repeat (CPB / 2) strobe_period(1'b0);
    strobe_period(ack_at_stop);
    if (ack_at_stop && exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
    if (accept_exp) begin
      if (!exp_valid) begin
        exp_data  = w;
        exp_valid = 1'b1;
      end else begin
        exp_overrun = 1'b1;
      end
    end
    if (frame_exp) exp_fe++;
    if (par_exp)   exp_pe++;
    check("stop_valid",   data_valid,  exp_valid);
    check("stop_data",    data_out,    exp_data);
    check("stop_overrun", overrun,     exp_overrun);
    check("stop_framing", framing_err, frame_exp);
    check("stop_parity",  parity_err,  par_exp);
    repeat (CPB / 2 - 1) strobe_period(1'b0);
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    @(posedge main_clk); #1;
    data_ack = 1'b0;
    if (exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
    check("ack_valid",   data_valid, exp_valid);
    check("ack_overrun", overrun,    exp_overrun);
  endtask

  task automatic model_reset();
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    exp_data    = '0;
  endtask

  initial begin
    logic [7:0] w;
    logic       stop_bit, par_bit;
    bit         ack_stop;

    div      = $urandom_range(6, 3);
    rst      = 1'b1;
    rx       = 1'b1;
    strobe   = 1'b0;
    data_ack = 1'b0;
    exp_fe   = 0;
    exp_pe   = 0;
    model_reset();
    repeat (3) @(posedge main_clk);
    #1 rst = 1'b0;

    check("rst_data",    data_out,    8'h00);
    check("rst_valid",   data_valid,  1'b0);
    check("rst_framing", framing_err, 1'b0);
    check("rst_parity",  parity_err,  1'b0);
    check("rst_overrun", overrun,     1'b0);
    check("rst_busy",    busy,        1'b0);

    // Ideal frame, then ack.
    send_bits(1'b1, CPB);
    send_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b0);
    do_ack();

    // Short start glitch.
    rx = 1'b0;
    repeat (2) strobe_period(1'b0);
    check("glitch_busy_hi", busy, 1'b1);
    rx = 1'b1;
    repeat (4) strobe_period(1'b0);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_valid",   data_valid, 1'b0);
    check("glitch_fe",      fe_count, exp_fe);

    // Framing error followed by a long break, then a good frame.
    send_frame(8'h3C, 1'b0, good_par(8'h3C), 1'b0);
    send_bits(1'b0, 20 * CPB);
    check("break_busy", busy, 1'b1);
    send_bits(1'b1, CPB);
    check("break_idle", busy, 1'b0);
    send_frame(8'h81, 1'b1, good_par(8'h81), 1'b0);
    check("break_fe_count", fe_count, exp_fe);
    do_ack();

    // Overrun on back-to-back frames without ack.
    send_frame(8'h11, 1'b1, good_par(8'h11), 1'b0);
    send_frame(8'h22, 1'b1, good_par(8'h22), 1'b0);
    do_ack();

    // Ack coincident with completion of the next word.
    send_frame(8'h44, 1'b1, good_par(8'h44), 1'b0);
    send_frame(8'h55, 1'b1, good_par(8'h55), 1'b1);
    do_ack();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check("parity_pe_count", pe_count, exp_pe);
    do_ack();
`endif

    // Reset in the middle of a frame while a word is held.
    send_frame(8'h9E, 1'b1, good_par(8'h9E), 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) strobe_period(1'b0);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge main_clk); #1;
    rst = 1'b0;
    model_reset();
    check("midrst_busy",  busy,       1'b0);
    check("midrst_valid", data_valid, 1'b0);
    check("midrst_data",  data_out,   8'h00);
    send_bits(1'b1, CPB);

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      w        = 8'($urandom);
      stop_bit = ($urandom_range(7) != 0);
      par_bit  = good_par(w) ^ ($urandom_range(5) == 0);
      ack_stop = ($urandom_range(5) == 0);
      send_frame(w, stop_bit, par_bit, ack_stop);
      if (!stop_bit) send_bits(1'b1, CPB);
      else           send_bits(1'b1, $urandom_range(2));
      if ($urandom_range(2) == 0) do_ack();
    end

    send_bits(1'b1, CPB);
    check("final_fe_count", fe_count, exp_fe);
    check("final_pe_count", pe_count, exp_pe);
    check("final_busy",     busy,     1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
